// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame length default and slave FSM state encoding.
package spi_pkg;

  localparam int unsigned SPI_TRF_BIT_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } slave_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with rise/fall strobes on the synchronized copy.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-1 responder: oversampled sclk/cs/mosi, MSB-first fixed-length frames,
// preloaded transmit buffer and single-cycle receive strobe.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SPI_TRF_BIT = SPI_TRF_BIT_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk,
  input  logic                   cs,
  input  logic                   mosi,
  output logic                   miso,
  input  logic [SPI_TRF_BIT-1:0] tx_data,
  input  logic                   tx_load,
  output logic                   tx_pending,
  output logic [SPI_TRF_BIT-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   tx_underrun
);

  localparam int unsigned W     = SPI_TRF_BIT;
  localparam int unsigned CNT_W = $clog2(SPI_TRF_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPI_TRF_BIT);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  slave_state_e     state_q, state_nxt;
  logic [W-1:0]     tx_buf_q, tx_buf_nxt;
  logic [W-1:0]     tx_shift_q, tx_shift_nxt;
  logic [W-1:0]     rx_shift_q, rx_shift_nxt;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_nxt;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_nxt;
  logic [W-1:0]     rx_data_nxt;
  logic             tx_pending_nxt, rx_valid_nxt, frame_err_nxt, tx_underrun_nxt;
  logic             miso_nxt, busy_nxt;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (sclk),
    .rise_c (sclk_rise),
    .fall_c (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (cs),
    .rise_c (cs_rise),
    .fall_c (cs_fall)
  );

  // Same depth as the sclk path so the sampled bit lines up with the detected falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync_q <= '0;
    else      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tx_buf_q    <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      tx_pending  <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      miso        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      tx_buf_q    <= tx_buf_nxt;
      tx_shift_q  <= tx_shift_nxt;
      rx_shift_q  <= rx_shift_nxt;
      tx_cnt_q    <= tx_cnt_nxt;
      rx_cnt_q    <= rx_cnt_nxt;
      tx_pending  <= tx_pending_nxt;
      rx_data     <= rx_data_nxt;
      rx_valid    <= rx_valid_nxt;
      frame_err   <= frame_err_nxt;
      tx_underrun <= tx_underrun_nxt;
      miso        <= miso_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt       = state_q;
    tx_buf_nxt      = tx_buf_q;
    tx_shift_nxt    = tx_shift_q;
    rx_shift_nxt    = rx_shift_q;
    tx_cnt_nxt      = tx_cnt_q;
    rx_cnt_nxt      = rx_cnt_q;
    tx_pending_nxt  = tx_pending;
    rx_data_nxt     = rx_data;
    rx_valid_nxt    = 1'b0;
    frame_err_nxt   = 1'b0;
    tx_underrun_nxt = 1'b0;
    miso_nxt        = miso;

    if (tx_load) begin
      tx_buf_nxt     = tx_data;
      tx_pending_nxt = 1'b1;
    end

    case (state_q)
      IDLE: begin
        miso_nxt = 1'b0;
        if (cs_fall) begin
          // A load coinciding with frame start is bypassed straight into the shifter.
          if (tx_load) begin
            tx_shift_nxt = tx_data;
          end else if (tx_pending) begin
            tx_shift_nxt = tx_buf_q;
          end else begin
            tx_shift_nxt    = '0;
            tx_underrun_nxt = 1'b1;
          end
          tx_pending_nxt = 1'b0;
          tx_cnt_nxt     = '0;
          rx_cnt_nxt     = '0;
          state_nxt      = SHIFT;
        end
      end

      SHIFT: begin
        if (rx_cnt_q == CNT_MAX) begin
          rx_data_nxt  = rx_shift_q;
          rx_valid_nxt = 1'b1;
          if (cs_rise) begin
            miso_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
          end
        end else if (cs_rise) begin
          // cs_rise wins over a coincident sclk_fall: the partial frame is dropped.
          frame_err_nxt = 1'b1;
          miso_nxt      = 1'b0;
          state_nxt     = IDLE;
        end else begin
          if (sclk_rise && (tx_cnt_q < CNT_MAX)) begin
            miso_nxt     = tx_shift_q[W-1];
            tx_shift_nxt = {tx_shift_q[W-2:0], 1'b0};
            tx_cnt_nxt   = tx_cnt_q + CNT_W'(1);
          end
          if (sclk_fall && (rx_cnt_q < CNT_MAX)) begin
            rx_shift_nxt = {rx_shift_q[W-2:0], mosi_s};
            rx_cnt_nxt   = rx_cnt_q + CNT_W'(1);
          end
        end
      end

      HOLD: begin
        if (sclk_rise && (tx_cnt_q == CNT_MAX)) miso_nxt = 1'b0;
        if (cs_rise) begin
          miso_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
